// File: rtl/pciecfg_exec.sv
// Executes NetTLP PCIe config requests: pops one FIFO_PCIECFG_T entry, runs a single
// cfg_mgmt DW read/write (with timeout) and pushes the response entry to the TX FIFO.
module pciecfg_exec #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        pcie_clk,
   input  logic        pcie_rst_n,
   input  logic        rx_empty,
   input  logic [64:0] rx_dout,
   output logic        rx_rd_en,
   input  logic [31:0] cfg_mgmt_do,
   input  logic        cfg_mgmt_rd_wr_done,
   output logic [31:0] cfg_mgmt_di,
   output logic [3:0]  cfg_mgmt_byte_en,
   output logic [9:0]  cfg_mgmt_dwaddr,
   output logic        cfg_mgmt_rd_en,
   output logic        cfg_mgmt_wr_en,
   output logic        cfg_mgmt_wr_readonly,
   input  logic        tx_full,
   output logic        tx_wr_en,
   output logic [64:0] tx_din,
   output logic        err_timeout,
   output logic [15:0] drop_cnt
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] OPC_RD = 2'b00;
   localparam logic [1:0] OPC_WR = 2'b01;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state;
   logic [15:0]      req_udp;
   logic [1:0]       req_opc;
   logic [3:0]       req_mask;
   logic [9:0]       req_addr;
   logic [31:0]      req_data;
   logic [CNT_W-1:0] cnt;
   logic             req_ok;
   logic             timeout_hit;
   logic [31:0]      result;

   assign cfg_mgmt_wr_readonly = 1'b0;

   // FIFO handshakes decode the registered state so drops can pop every cycle and the
   // push lands on the first non-full cycle; reset gates them so nothing moves in reset.
   assign rx_rd_en    = pcie_rst_n && (state == IDLE) && !rx_empty;
   assign tx_wr_en    = pcie_rst_n && (state == RESP) && !tx_full;
   assign timeout_hit = (state == ACCESS) && (cnt == CNT_LAST) && !cfg_mgmt_rd_wr_done;
   assign err_timeout = pcie_rst_n && timeout_hit;

   assign req_ok = rx_dout[64] && ((rx_dout[47:46] == OPC_RD) || (rx_dout[47:46] == OPC_WR));

   always_comb begin
      result = 32'hFFFF_FFFF;
      if (cfg_mgmt_rd_wr_done)
         result = (req_opc == OPC_RD) ? cfg_mgmt_do : req_data;
   end

   always_ff @(posedge pcie_clk) begin
      if (!pcie_rst_n) begin
         state            <= IDLE;
         cfg_mgmt_rd_en   <= 1'b0;
         cfg_mgmt_wr_en   <= 1'b0;
         cfg_mgmt_di      <= '0;
         cfg_mgmt_byte_en <= '0;
         cfg_mgmt_dwaddr  <= '0;
         tx_din           <= '0;
         drop_cnt         <= '0;
         cnt              <= '0;
         req_udp          <= '0;
         req_opc          <= '0;
         req_mask         <= '0;
         req_addr         <= '0;
         req_data         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_empty) begin
                  req_udp  <= rx_dout[63:48];
                  req_opc  <= rx_dout[47:46];
                  req_mask <= rx_dout[45:42];
                  req_addr <= rx_dout[41:32];
                  req_data <= rx_dout[31:0];
                  if (!req_ok) begin
                     if (drop_cnt != 16'hFFFF)
                        drop_cnt <= drop_cnt + 16'd1;
                  end else if ((rx_dout[47:46] == OPC_WR) && (rx_dout[45:42] == 4'h0)) begin
                     tx_din <= {1'b1, rx_dout[63:0]};
                     state  <= RESP;
                  end else begin
                     cnt             <= '0;
                     cfg_mgmt_dwaddr <= rx_dout[41:32];
                     cfg_mgmt_di     <= rx_dout[31:0];
                     if (rx_dout[47:46] == OPC_RD) begin
                        cfg_mgmt_byte_en <= 4'hF;
                        cfg_mgmt_rd_en   <= 1'b1;
                     end else begin
                        cfg_mgmt_byte_en <= rx_dout[45:42];
                        cfg_mgmt_wr_en   <= 1'b1;
                     end
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (cfg_mgmt_rd_wr_done || timeout_hit) begin
                  cfg_mgmt_rd_en <= 1'b0;
                  cfg_mgmt_wr_en <= 1'b0;
                  tx_din         <= {1'b1, req_udp, req_opc, req_mask, req_addr, result};
                  state          <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (!tx_full)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pciecfg_exec.sv
// Directed bench for pciecfg_exec: FIFO and cfg_mgmt models, per-cycle monitor, and
// hand-computed expectations for each request scenario.
module tb_pciecfg_exec;

   logic        pcie_clk = 1'b0;
   logic        pcie_rst_n = 1'b0;
   logic        rx_empty = 1'b1;
   logic [64:0] rx_dout = '0;
   logic [31:0] cfg_mgmt_do = '0;
   logic        cfg_mgmt_rd_wr_done = 1'b0;
   logic        tx_full = 1'b0;
   logic        rx_rd_en, cfg_mgmt_rd_en, cfg_mgmt_wr_en, cfg_mgmt_wr_readonly;
   logic        tx_wr_en, err_timeout;
   logic [31:0] cfg_mgmt_di;
   logic [3:0]  cfg_mgmt_byte_en;
   logic [9:0]  cfg_mgmt_dwaddr;
   logic [64:0] tx_din;
   logic [15:0] drop_cnt;

   pciecfg_exec #(.TIMEOUT_CYCLES(16)) dut (
      .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
      .rx_empty(rx_empty), .rx_dout(rx_dout), .rx_rd_en(rx_rd_en),
      .cfg_mgmt_do(cfg_mgmt_do), .cfg_mgmt_rd_wr_done(cfg_mgmt_rd_wr_done),
      .cfg_mgmt_di(cfg_mgmt_di), .cfg_mgmt_byte_en(cfg_mgmt_byte_en),
      .cfg_mgmt_dwaddr(cfg_mgmt_dwaddr), .cfg_mgmt_rd_en(cfg_mgmt_rd_en),
      .cfg_mgmt_wr_en(cfg_mgmt_wr_en), .cfg_mgmt_wr_readonly(cfg_mgmt_wr_readonly),
      .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_din(tx_din),
      .err_timeout(err_timeout), .drop_cnt(drop_cnt)
   );

   always #5 pcie_clk = ~pcie_clk;

   int errors = 0;
   int checks = 0;

   logic [64:0] rxq[$];
   logic        tx_full_v = 1'b0;
   int          done_at = 0;
   logic [31:0] rd_data_v = '0;
   logic [3:0]  exp_be = '0;
   logic [31:0] exp_di = '0;
   logic [9:0]  exp_addr = '0;

   int cyc = 0, scnt = 0, both_high = 0;
   int rd_cycles, wr_cycles, tx_cnt, pop_cnt, err_cnt, hold_bad;
   int first_strobe, err_cyc, tx_first, pop_first, pop_second, rel_cyc;
   logic [64:0] last_tx;
   logic pop_pending = 1'b0;

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [64:0] mk(input logic v, input logic [15:0] udp, input logic [1:0] opc,
                                      input logic [3:0] mask, input logic [9:0] addr,
                                      input logic [31:0] data);
      return {v, udp, opc, mask, addr, data};
   endfunction

   task automatic clear_mon();
      rd_cycles = 0; wr_cycles = 0; tx_cnt = 0; pop_cnt = 0; err_cnt = 0; hold_bad = 0;
      first_strobe = -1; err_cyc = -1; tx_first = -1; pop_first = -1; pop_second = -1;
      rel_cyc = -1; last_tx = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge pcie_clk);
   endtask

   // Input driving at the falling edge, output sampling 1 ns later.
   initial begin
      clear_mon();
      forever begin
         @(negedge pcie_clk);
         cyc++;
         if (pop_pending) begin
            void'(rxq.pop_front());
            pop_pending = 1'b0;
         end
         rx_empty = (rxq.size() == 0);
         rx_dout  = rx_empty ? '0 : rxq[0];
         if (tx_full && !tx_full_v) rel_cyc = cyc;
         tx_full = tx_full_v;
         if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
            scnt++;
            cfg_mgmt_rd_wr_done = (scnt == done_at);
            cfg_mgmt_do = rd_data_v;
         end else begin
            scnt = 0;
            cfg_mgmt_rd_wr_done = 1'b0;
            cfg_mgmt_do = '0;
         end
         #1;
         if (cfg_mgmt_rd_en) rd_cycles++;
         if (cfg_mgmt_wr_en) wr_cycles++;
         if ((cfg_mgmt_rd_en || cfg_mgmt_wr_en) && first_strobe < 0) first_strobe = cyc;
         if ((cfg_mgmt_rd_en || cfg_mgmt_wr_en) &&
             ({cfg_mgmt_byte_en, cfg_mgmt_di, cfg_mgmt_dwaddr} != {exp_be, exp_di, exp_addr}))
            hold_bad++;
         if (err_timeout) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (tx_wr_en) begin
            tx_cnt++;
            last_tx = tx_din;
            if (tx_first < 0) tx_first = cyc;
         end
         if (rx_rd_en && tx_wr_en) both_high++;
         if (rx_rd_en) begin
            pop_cnt++;
            if (pop_first < 0) pop_first = cyc;
            else if (pop_second < 0) pop_second = cyc;
            pop_pending = 1'b1;
         end
      end
   end

   initial begin
      // Reset state
      wait_cycles(3);
      #2;
      check("rst_rd_en", cfg_mgmt_rd_en, 0);
      check("rst_wr_en", cfg_mgmt_wr_en, 0);
      check("rst_tx_wr_en", tx_wr_en, 0);
      check("rst_err", err_timeout, 0);
      check("rst_tx_din", tx_din, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_cfg_regs", {cfg_mgmt_byte_en, cfg_mgmt_di, cfg_mgmt_dwaddr}, 0);
      @(negedge pcie_clk);
      pcie_rst_n = 1'b1;
      wait_cycles(2);
      check("idle_rx_rd_en", rx_rd_en, 0);
      check("wr_readonly", cfg_mgmt_wr_readonly, 0);

      // Config read, done on the third strobe cycle
      clear_mon();
      done_at = 3; rd_data_v = 32'h7001_10EE;
      exp_be = 4'hF; exp_di = 32'h0; exp_addr = 10'h000;
      rxq.push_back(mk(1'b1, 16'h1234, 2'b00, 4'hF, 10'h000, 32'h0));
      wait_cycles(20);
      check("rd_cycles", rd_cycles, 3);
      check("rd_no_wr", wr_cycles, 0);
      check("rd_tx_cnt", tx_cnt, 1);
      check("rd_tx_din", last_tx, mk(1'b1, 16'h1234, 2'b00, 4'hF, 10'h000, 32'h7001_10EE));
      check("rd_hold", hold_bad, 0);
      check("rd_latency", tx_first - pop_first, 4);
      check("rd_no_err", err_cnt, 0);

      // Config write to BAR0
      clear_mon();
      done_at = 2; rd_data_v = 32'h1234_5678;
      exp_be = 4'hF; exp_di = 32'hFFFF_FFFF; exp_addr = 10'h004;
      rxq.push_back(mk(1'b1, 16'hA5A5, 2'b01, 4'hF, 10'h004, 32'hFFFF_FFFF));
      wait_cycles(20);
      check("wr_cycles", wr_cycles, 2);
      check("wr_no_rd", rd_cycles, 0);
      check("wr_hold", hold_bad, 0);
      check("wr_tx_din", last_tx, mk(1'b1, 16'hA5A5, 2'b01, 4'hF, 10'h004, 32'hFFFF_FFFF));

      // Two discards back to back, then a valid read
      clear_mon();
      done_at = 1; rd_data_v = 32'hCAFE_F00D;
      exp_be = 4'hF; exp_di = 32'h5555_0000; exp_addr = 10'h010;
      rxq.push_back(mk(1'b0, 16'h0001, 2'b00, 4'hF, 10'h020, 32'h1));
      rxq.push_back(mk(1'b1, 16'h0002, 2'b10, 4'hF, 10'h030, 32'h2));
      rxq.push_back(mk(1'b1, 16'h0003, 2'b00, 4'hF, 10'h010, 32'h5555_0000));
      wait_cycles(20);
      check("drop_cnt", drop_cnt, 2);
      check("drop_pops", pop_cnt, 3);
      check("drop_b2b", pop_second - pop_first, 1);
      check("drop_tx_cnt", tx_cnt, 1);
      check("drop_rd_cycles", rd_cycles, 1);
      check("drop_tx_din", last_tx, mk(1'b1, 16'h0003, 2'b00, 4'hF, 10'h010, 32'hCAFE_F00D));
      check("drop_hold", hold_bad, 0);

      // Timeout with done never asserted
      clear_mon();
      done_at = 0; rd_data_v = 32'h0BAD_0BAD;
      exp_be = 4'hF; exp_di = 32'h0; exp_addr = 10'h03F;
      rxq.push_back(mk(1'b1, 16'h7777, 2'b00, 4'h3, 10'h03F, 32'h0));
      wait_cycles(30);
      check("to_rd_cycles", rd_cycles, 16);
      check("to_err_cnt", err_cnt, 1);
      check("to_err_last", err_cyc - first_strobe, 15);
      check("to_tx_din", last_tx, mk(1'b1, 16'h7777, 2'b00, 4'h3, 10'h03F, 32'hFFFF_FFFF));

      // Done in the same cycle as the timeout wins
      clear_mon();
      done_at = 16; rd_data_v = 32'h1357_9BDF;
      exp_be = 4'hF; exp_di = 32'h0; exp_addr = 10'h001;
      rxq.push_back(mk(1'b1, 16'h8888, 2'b00, 4'hF, 10'h001, 32'h0));
      wait_cycles(30);
      check("edge_rd_cycles", rd_cycles, 16);
      check("edge_no_err", err_cnt, 0);
      check("edge_tx_din", last_tx, mk(1'b1, 16'h8888, 2'b00, 4'hF, 10'h001, 32'h1357_9BDF));

      // Write with empty byte mask skips the access
      clear_mon();
      rxq.push_back(mk(1'b1, 16'h0BAD, 2'b01, 4'h0, 10'h00C, 32'hDEAD_BEEF));
      wait_cycles(10);
      check("wr0_no_access", rd_cycles + wr_cycles, 0);
      check("wr0_tx_din", last_tx, mk(1'b1, 16'h0BAD, 2'b01, 4'h0, 10'h00C, 32'hDEAD_BEEF));

      // TX back-pressure holds the response and blocks RX
      clear_mon();
      tx_full_v = 1'b1;
      done_at = 1; rd_data_v = 32'h0000_ABCD;
      exp_be = 4'hF; exp_di = 32'h0; exp_addr = 10'h002;
      rxq.push_back(mk(1'b1, 16'h1111, 2'b00, 4'hF, 10'h002, 32'h0));
      rxq.push_back(mk(1'b1, 16'h2222, 2'b00, 4'hF, 10'h002, 32'h0));
      wait_cycles(12);
      check("full_no_tx", tx_cnt, 0);
      check("full_one_pop", pop_cnt, 1);
      tx_full_v = 1'b0;
      wait_cycles(15);
      check("full_first_tx", tx_first - rel_cyc, 0);
      check("full_tx_cnt", tx_cnt, 2);
      check("full_pops", pop_cnt, 2);
      check("full_last_tx", last_tx, mk(1'b1, 16'h2222, 2'b00, 4'hF, 10'h002, 32'h0000_ABCD));

      // Reset during ACCESS loses the request; the next one runs cleanly
      clear_mon();
      done_at = 0;
      exp_be = 4'hF; exp_di = 32'h0; exp_addr = 10'h005;
      rxq.push_back(mk(1'b1, 16'h3333, 2'b00, 4'hF, 10'h005, 32'h0));
      wait_cycles(5);
      pcie_rst_n = 1'b0;
      @(negedge pcie_clk);
      pcie_rst_n = 1'b1;
      #2;
      check("rstmid_rd_low", cfg_mgmt_rd_en, 0);
      wait_cycles(25);
      check("rstmid_no_tx", tx_cnt, 0);
      check("rstmid_no_err", err_cnt, 0);
      clear_mon();
      done_at = 2; rd_data_v = 32'h2468_ACE0;
      exp_be = 4'hF; exp_di = 32'h0; exp_addr = 10'h006;
      rxq.push_back(mk(1'b1, 16'h4444, 2'b00, 4'hF, 10'h006, 32'h0));
      wait_cycles(15);
      check("after_rst_rd", rd_cycles, 2);
      check("after_rst_tx", last_tx, mk(1'b1, 16'h4444, 2'b00, 4'hF, 10'h006, 32'h2468_ACE0));
      check("after_rst_hold", hold_bad, 0);

      check("never_pop_and_push", both_high, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
